// File: rtl/clk_reset_sequencer.sv
// MMCM supervisor: drives MMCM reset, waits for a stable lock with bounded retries,
// then releases peripheral reset followed by core reset after a fixed stagger.
module clk_reset_sequencer #(
    parameter int SYNC_STAGES     = 2,
    parameter int MMCM_RST_CYCLES = 16,
    parameter int LOCK_TIMEOUT    = 65536,
    parameter int STABLE_CYCLES   = 256,
    parameter int STAGGER_CYCLES  = 16,
    parameter int MAX_RETRIES     = 7
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       mmcm_locked_async,
    output logic       mmcm_reset,
    output logic       rst_periph,
    output logic       rst_core,
    output logic       ready,
    output logic       lock_fail,
    output logic [3:0] retry_count
);

    localparam int MAX_A     = (MMCM_RST_CYCLES > LOCK_TIMEOUT) ? MMCM_RST_CYCLES : LOCK_TIMEOUT;
    localparam int MAX_B     = (STABLE_CYCLES > STAGGER_CYCLES) ? STABLE_CYCLES : STAGGER_CYCLES;
    localparam int MAX_COUNT = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CNT_W     = (MAX_COUNT > 1) ? $clog2(MAX_COUNT) : 1;

    localparam logic [CNT_W-1:0] MRST_LAST    = CNT_W'(MMCM_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] STAGGER_LAST = CNT_W'(STAGGER_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
    localparam logic [3:0]       RETRY_LIMIT  = 4'(MAX_RETRIES);

    localparam logic [2:0] ST_MMCM_RST  = 3'd0;
    localparam logic [2:0] ST_WAIT_LOCK = 3'd1;
    localparam logic [2:0] ST_STABLE    = 3'd2;
    localparam logic [2:0] ST_PERIPH    = 3'd3;
    localparam logic [2:0] ST_RUN       = 3'd4;
    localparam logic [2:0] ST_FAIL      = 3'd5;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [2:0]             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [3:0]             retry_q, retry_d;
    logic                   mmcm_reset_q, mmcm_reset_d;
    logic                   rst_periph_q, rst_periph_d;
    logic                   rst_core_q, rst_core_d;
    logic                   ready_q, ready_d;
    logic                   lock_fail_q, lock_fail_d;
    logic                   locked_s;

    assign sync_d[0] = mmcm_locked_async;
    for (genvar gi = 1; gi < SYNC_STAGES; gi++) begin : g_sync
        assign sync_d[gi] = sync_q[gi-1];
    end
    assign locked_s = sync_q[SYNC_STAGES-1];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        retry_d = retry_q;
        case (state_q)
            ST_MMCM_RST: begin
                if (cnt_q == MRST_LAST) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_WAIT_LOCK: begin
                // Lock arriving on the timeout cycle takes priority over a retry.
                if (locked_s) begin
                    state_d = ST_STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    cnt_d = '0;
                    if (retry_q == RETRY_LIMIT) begin
                        state_d = ST_FAIL;
                    end else begin
                        retry_d = retry_q + 4'd1;
                        state_d = ST_MMCM_RST;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_STABLE: begin
                if (!locked_s) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = ST_PERIPH;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_PERIPH: begin
                if (!locked_s) begin
                    state_d = ST_MMCM_RST;
                    cnt_d   = '0;
                end else if (cnt_q == STAGGER_LAST) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                    retry_d = 4'd0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_RUN: begin
                if (!locked_s) begin
                    state_d = ST_MMCM_RST;
                    cnt_d   = '0;
                end
            end
            ST_FAIL: begin
                state_d = ST_FAIL;
            end
            default: begin
                state_d = ST_MMCM_RST;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs come from the next state so they change on the same edge as the state.
    always_comb begin
        mmcm_reset_d = (state_d == ST_MMCM_RST) || (state_d == ST_FAIL);
        rst_periph_d = !((state_d == ST_PERIPH) || (state_d == ST_RUN));
        rst_core_d   = (state_d != ST_RUN);
        ready_d      = (state_d == ST_RUN);
        lock_fail_d  = (state_d == ST_FAIL);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q       <= '0;
            state_q      <= ST_MMCM_RST;
            cnt_q        <= '0;
            retry_q      <= 4'd0;
            mmcm_reset_q <= 1'b1;
            rst_periph_q <= 1'b1;
            rst_core_q   <= 1'b1;
            ready_q      <= 1'b0;
            lock_fail_q  <= 1'b0;
        end else begin
            sync_q       <= sync_d;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            retry_q      <= retry_d;
            mmcm_reset_q <= mmcm_reset_d;
            rst_periph_q <= rst_periph_d;
            rst_core_q   <= rst_core_d;
            ready_q      <= ready_d;
            lock_fail_q  <= lock_fail_d;
        end
    end

    assign mmcm_reset  = mmcm_reset_q;
    assign rst_periph  = rst_periph_q;
    assign rst_core    = rst_core_q;
    assign ready       = ready_q;
    assign lock_fail   = lock_fail_q;
    assign retry_count = retry_q;

endmodule

// File: tb/tb_clk_reset_sequencer.sv
// Randomized bench for clk_reset_sequencer against a phase/dwell-time reference model.
module tb_clk_reset_sequencer;

    localparam int SYNC = 2;
    localparam int MRST = 4;
    localparam int TO   = 32;
    localparam int STAB = 8;
    localparam int STAG = 4;
    localparam int MAXR = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       lk = 1'b0;
    logic       mmcm_reset, rst_periph, rst_core, ready, lock_fail;
    logic [3:0] retry_count;

    int n_cmp = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    clk_reset_sequencer #(
        .SYNC_STAGES    (SYNC),
        .MMCM_RST_CYCLES(MRST),
        .LOCK_TIMEOUT   (TO),
        .STABLE_CYCLES  (STAB),
        .STAGGER_CYCLES (STAG),
        .MAX_RETRIES    (MAXR)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .mmcm_locked_async(lk),
        .mmcm_reset       (mmcm_reset),
        .rst_periph       (rst_periph),
        .rst_core         (rst_core),
        .ready            (ready),
        .lock_fail        (lock_fail),
        .retry_count      (retry_count)
    );

    // Reference model: current phase, the edge it was entered on, and the raw lock samples.
    typedef enum int {P_MRST, P_WAIT, P_STAB, P_PER, P_RUN, P_FAIL} phase_t;
    phase_t phase   = P_MRST;
    int     t_enter = 0;
    int     edge_n  = 0;
    int     retries = 0;
    logic   hist[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic enter(input phase_t p);
        phase   = p;
        t_enter = edge_n;
    endtask

    // Each phase lasts a whole number of edges; age counts edges since the phase was entered.
    task automatic model_step(input logic l, input logic r);
        logic ls;
        int   age;
        if (r) begin
            enter(P_MRST);
            retries = 0;
            hist.delete();
        end else begin
            ls  = (hist.size() >= SYNC) ? hist[hist.size() - SYNC] : 1'b0;
            age = edge_n - t_enter;
            case (phase)
                P_MRST: if (age == MRST) enter(P_WAIT);
                P_WAIT: begin
                    if (ls) enter(P_STAB);
                    else if (age == TO) begin
                        if (retries == MAXR) enter(P_FAIL);
                        else begin
                            retries++;
                            enter(P_MRST);
                        end
                    end
                end
                P_STAB: begin
                    if (!ls) enter(P_WAIT);
                    else if (age == STAB) enter(P_PER);
                end
                P_PER: begin
                    if (!ls) enter(P_MRST);
                    else if (age == STAG) begin
                        retries = 0;
                        enter(P_RUN);
                    end
                end
                P_RUN:  if (!ls) enter(P_MRST);
                default: ;
            endcase
            hist.push_back(l);
            if (hist.size() > SYNC) void'(hist.pop_front());
        end
        edge_n++;
    endtask

    task automatic tick(input logic l, input logic r);
        lk    = l;
        reset = r;
        @(posedge clk);
        model_step(l, r);
        #1;
        chk("mmcm_reset",  mmcm_reset, (phase == P_MRST) || (phase == P_FAIL));
        chk("rst_periph",  rst_periph, !((phase == P_PER) || (phase == P_RUN)));
        chk("rst_core",    rst_core,   phase != P_RUN);
        chk("ready",       ready,      phase == P_RUN);
        chk("lock_fail",   lock_fail,  phase == P_FAIL);
        chk("retry_count", retry_count, retries);
    endtask

    task automatic high_until_ready(input string tag, input int budget);
        for (int i = 0; i < budget; i++) begin
            tick(1'b1, 1'b0);
            if (ready) break;
        end
        chk(tag, ready, 1);
    endtask

    initial begin
        int lat, core_lat, hc, released, gap;
        logic lvl;

        $display("scenario 1: power-up sequence");
        repeat (3) tick(1'b0, 1'b1);
        chk("reset_mmcm_reset", mmcm_reset, 1);
        chk("reset_rst_core",   rst_core, 1);
        chk("reset_ready",      ready, 0);
        hc = 0;
        for (int i = 0; i < 6; i++) begin
            tick(1'b0, 1'b0);
            if (mmcm_reset) hc++;
        end
        // The cycle right after reset release is the first of the pulse.
        chk("mmcm_pulse_len", hc + 1, MRST);
        repeat (4) tick(1'b0, 1'b0);
        lat = -1;
        core_lat = -1;
        for (int i = 0; i < 60; i++) begin
            tick(1'b1, 1'b0);
            if (!rst_periph && lat < 0) lat = i;
            if (!rst_core) begin
                core_lat = i;
                break;
            end
        end
        chk("periph_latency", lat, SYNC + STAB);
        chk("core_stagger", core_lat - lat, STAG);
        chk("run_retry_count", retry_count, 0);

        $display("scenario 4: one-cycle lock drop in RUN");
        repeat (5) tick(1'b1, 1'b0);
        lat = -1;
        for (int i = 0; i < 10; i++) begin
            tick((i == 0) ? 1'b0 : 1'b1, 1'b0);
            if (!ready && lat < 0) lat = i;
        end
        chk("drop_latency", lat, SYNC);
        high_until_ready("reacquire_after_drop", 100);

        $display("scenario 2: lock never arrives");
        for (int i = 0; i < 300; i++) begin
            tick(1'b0, 1'b0);
            if (lock_fail) break;
        end
        chk("lock_fail_reached", lock_fail, 1);
        chk("fail_retry_count", retry_count, MAXR);
        repeat (20) tick(1'b1, 1'b0);
        chk("fail_terminal", mmcm_reset & lock_fail & rst_periph, 1);
        repeat (2) tick(1'b1, 1'b1);

        $display("scenario 5: reset during PERIPH");
        for (int i = 0; i < 60; i++) begin
            tick(1'b1, 1'b0);
            if (!rst_periph) break;
        end
        chk("reached_periph", rst_periph, 0);
        tick(1'b1, 1'b1);
        chk("midreset_rst_periph", rst_periph, 1);
        chk("midreset_mmcm_reset", mmcm_reset, 1);
        repeat (6) tick(1'b0, 1'b0);

        $display("scenario 3: short lock pulses then steady lock");
        released = 0;
        for (int p = 0; p < 4; p++) begin
            repeat ($urandom_range(1, STAB - 1)) begin
                tick(1'b1, 1'b0);
                if (!rst_periph) released++;
            end
            gap = $urandom_range(1, 4);
            repeat (gap) begin
                tick(1'b0, 1'b0);
                if (!rst_periph) released++;
            end
        end
        chk("no_release_on_pulse", released, 0);
        lat = -1;
        for (int i = 0; i < 30; i++) begin
            tick(1'b1, 1'b0);
            if (!rst_periph) begin
                lat = i;
                break;
            end
        end
        chk("steady_latency", lat, SYNC + STAB);
        chk("pulse_retry_count", retry_count, 0);
        high_until_ready("ready_after_pulses", 20);

        $display("scenario 6: one timeout then lock");
        for (int i = 0; i < 100; i++) begin
            tick(1'b0, 1'b0);
            if (retry_count == 4'd1) break;
        end
        chk("one_timeout", retry_count, 1);
        high_until_ready("ready_after_timeout", 80);
        chk("retry_cleared", retry_count, 0);

        $display("scenario 7: random lock activity");
        lvl = 1'b1;
        for (int s = 0; s < 60; s++) begin
            lvl = ~lvl;
            if ($urandom_range(0, 19) == 0) tick(lvl, 1'b1);
            repeat ($urandom_range(1, 50)) tick(lvl, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
